// File: rtl/mlt3_stuff_encoder_if.sv
// Payload handshake and MLT-3 line-side bundle for mlt3_stuff_encoder.
// master = bit source / line consumer, slave = encoder.
interface mlt3_stuff_encoder_if #(
   parameter int unsigned CNT_W = 16
);
   logic              in_bit;
   logic              in_valid;
   logic              in_ready;
   logic              out_valid;
   logic signed [1:0] out_level;
   logic [1:0]        out_code;
   logic              out_stuffed;
   logic              run_hit;
   logic [CNT_W-1:0]  stuff_cnt;

   modport master (
      output in_bit, in_valid,
      input  in_ready, out_valid, out_level, out_code, out_stuffed, run_hit, stuff_cnt
   );

   modport slave (
      input  in_bit, in_valid,
      output in_ready, out_valid, out_level, out_code, out_stuffed, run_hit, stuff_cnt
   );
endinterface

// File: rtl/mlt3_stuff_encoder.sv
// MLT-3 line encoder with run-length-limiting bit stuffing and valid/ready input.
// Stuffing is built only when MLT3_STUFF_EN is defined; otherwise run_hit is status-only.
module mlt3_stuff_encoder #(
   parameter int unsigned MAX_RUN   = 6,
   parameter int unsigned CNT_W     = 16,
   parameter logic [1:0]  RST_STATE = 2'b01
) (
   input logic                 clk,
   input logic                 rst,
   mlt3_stuff_encoder_if.slave bus
);
   localparam int unsigned      RUN_W   = $clog2(MAX_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

   localparam logic signed [1:0] LVL_POS  = 2'sb01;
   localparam logic signed [1:0] LVL_ZERO = 2'sb00;
   localparam logic signed [1:0] LVL_NEG  = 2'sb11;

   typedef enum logic [1:0] {
      TOP    = 2'b00,
      DOWN   = 2'b01,
      BOTTOM = 2'b10,
      UP     = 2'b11
   } state_t;

   function automatic logic signed [1:0] level_of(input state_t s);
      case (s)
         TOP:     level_of = LVL_POS;
         BOTTOM:  level_of = LVL_NEG;
         default: level_of = LVL_ZERO;
      endcase
   endfunction

   state_t            state_q;
   logic [RUN_W-1:0]  run_len_q, run_len_d;
   logic              last_bit_q, last_bit_d;
   logic              out_valid_q;
   logic              out_stuffed_q;
   logic              run_hit_q;
   logic signed [1:0] out_level_q;

   logic run_at_max;
   logic stuff_now;
   logic in_ready;
   logic accept;
   logic line_vld;
   logic line_bit;

   assign run_at_max = (run_len_q == RUN_MAX);

`ifdef MLT3_STUFF_EN
   logic [CNT_W-1:0] stuff_cnt_q;

   // The stuff bit is forced regardless of in_valid, so the run never exceeds MAX_RUN.
   assign stuff_now = run_at_max;

   always_ff @(posedge clk) begin
      if (rst) begin
         stuff_cnt_q <= '0;
      end else if (stuff_now && (stuff_cnt_q != '1)) begin
         stuff_cnt_q <= stuff_cnt_q + CNT_W'(1);
      end
   end

   assign bus.stuff_cnt = stuff_cnt_q;
`else
   assign stuff_now     = 1'b0;
   assign bus.stuff_cnt = '0;
`endif

   assign in_ready = ~stuff_now;
   assign accept   = bus.in_valid & in_ready;
   assign line_vld = stuff_now | accept;
   assign line_bit = stuff_now ? ~last_bit_q : bus.in_bit;

   // NOTE: every output of always_comb gets a default first so no latch is inferred on idle cycles.
   always_comb begin
      run_len_d  = run_len_q;
      last_bit_d = last_bit_q;
      if (line_vld) begin
         last_bit_d = line_bit;
         if (line_bit != last_bit_q) begin
            run_len_d = RUN_ONE;
         end else if (!run_at_max) begin
            run_len_d = run_len_q + RUN_ONE;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= state_t'(RST_STATE);
         out_level_q   <= level_of(state_t'(RST_STATE));
         run_len_q     <= '0;
         last_bit_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         out_stuffed_q <= 1'b0;
         run_hit_q     <= 1'b0;
      end else begin
         run_len_q     <= run_len_d;
         last_bit_q    <= last_bit_d;
         out_valid_q   <= line_vld;
         out_stuffed_q <= stuff_now;
         run_hit_q     <= (run_len_d == RUN_MAX);
         if (line_vld && line_bit) begin
            case (state_q)
               TOP: begin
                  state_q     <= DOWN;
                  out_level_q <= LVL_ZERO;
               end
               DOWN: begin
                  state_q     <= BOTTOM;
                  out_level_q <= LVL_NEG;
               end
               BOTTOM: begin
                  state_q     <= UP;
                  out_level_q <= LVL_ZERO;
               end
               default: begin
                  state_q     <= TOP;
                  out_level_q <= LVL_POS;
               end
            endcase
         end
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_level   = out_level_q;
   assign bus.out_code    = state_q;
   assign bus.out_stuffed = out_stuffed_q;
   assign bus.run_hit     = run_hit_q;
endmodule

// File: tb/tb_mlt3_stuff_encoder.sv
// Directed bench for mlt3_stuff_encoder (MAX_RUN=6, CNT_W=2 to reach counter saturation).
// Expectations follow the build: stuffing when MLT3_STUFF_EN is defined, status-only otherwise.
module tb_mlt3_stuff_encoder;
   localparam int unsigned CNT_W = 2;

   typedef struct {
      logic              v;
      logic              b;
      logic              rdy;
      logic              ov;
      logic [1:0]        code;
      logic signed [1:0] lvl;
      logic              st;
      logic              hit;
      logic [1:0]        cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t tbl[$];

   mlt3_stuff_encoder_if #(.CNT_W(CNT_W)) bus ();

   mlt3_stuff_encoder #(
      .MAX_RUN  (6),
      .CNT_W    (CNT_W),
      .RST_STATE(2'b01)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v, b, rdy, ov, input logic [1:0] code,
                               input logic signed [1:0] lvl, input logic st, hit,
                               input logic [1:0] cnt);
      vec_t r;
      r.v = v; r.b = b; r.rdy = rdy; r.ov = ov; r.code = code;
      r.lvl = lvl; r.st = st; r.hit = hit; r.cnt = cnt;
      return r;
   endfunction

   // One cycle: drive at negedge, check in_ready combinationally, check registered outputs after posedge.
   task automatic step(input logic r, input vec_t e, input string tag);
      @(negedge clk);
      rst          = r;
      bus.in_valid = e.v;
      bus.in_bit   = e.b;
      #1;
      check({tag, ".in_ready"}, 8'(bus.in_ready), 8'(e.rdy));
      @(posedge clk);
      #1;
      check({tag, ".out_valid"},   8'(bus.out_valid),   8'(e.ov));
      check({tag, ".out_code"},    8'(bus.out_code),    8'(e.code));
      check({tag, ".out_level"},   8'(bus.out_level),   8'(e.lvl));
      check({tag, ".out_stuffed"}, 8'(bus.out_stuffed), 8'(e.st));
      check({tag, ".run_hit"},     8'(bus.run_hit),     8'(e.hit));
      check({tag, ".stuff_cnt"},   8'(bus.stuff_cnt),   8'(e.cnt));
   endtask

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_bit   = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("reset.out_code",    8'(bus.out_code),    8'h01);
      check("reset.out_level",   8'(bus.out_level),   8'h00);
      check("reset.out_valid",   8'(bus.out_valid),   8'h00);
      check("reset.out_stuffed", 8'(bus.out_stuffed), 8'h00);
      check("reset.run_hit",     8'(bus.run_hit),     8'h00);
      check("reset.stuff_cnt",   8'(bus.stuff_cnt),   8'h00);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset.in_ready", 8'(bus.in_ready), 8'h01);

`ifdef MLT3_STUFF_EN
      //              v  b  rdy ov code   lvl  st hit cnt
      tbl.push_back(mk(1, 1, 1, 1, 2'b10, -2'sd1, 0, 0, 2'd0));
      tbl.push_back(mk(1, 1, 1, 1, 2'b11,  2'sd0, 0, 0, 2'd0));
      tbl.push_back(mk(1, 1, 1, 1, 2'b00,  2'sd1, 0, 0, 2'd0));
      tbl.push_back(mk(1, 1, 1, 1, 2'b01,  2'sd0, 0, 0, 2'd0));
      tbl.push_back(mk(1, 1, 1, 1, 2'b10, -2'sd1, 0, 0, 2'd0));
      tbl.push_back(mk(1, 1, 1, 1, 2'b11,  2'sd0, 0, 1, 2'd0));
      tbl.push_back(mk(1, 1, 0, 1, 2'b11,  2'sd0, 1, 0, 2'd1));
      tbl.push_back(mk(1, 1, 1, 1, 2'b00,  2'sd1, 0, 0, 2'd1));
      tbl.push_back(mk(1, 1, 1, 1, 2'b01,  2'sd0, 0, 0, 2'd1));
      tbl.push_back(mk(1, 0, 1, 1, 2'b01,  2'sd0, 0, 0, 2'd1));
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(1, 0, 1, 1, 2'b01, 2'sd0, 0, 0, 2'd1));
      tbl.push_back(mk(1, 0, 1, 1, 2'b01,  2'sd0, 0, 1, 2'd1));
      tbl.push_back(mk(1, 0, 0, 1, 2'b10, -2'sd1, 1, 0, 2'd2));
      tbl.push_back(mk(0, 0, 1, 0, 2'b10, -2'sd1, 0, 0, 2'd2));
      tbl.push_back(mk(1, 0, 1, 1, 2'b10, -2'sd1, 0, 0, 2'd2));
      tbl.push_back(mk(1, 1, 1, 1, 2'b11,  2'sd0, 0, 0, 2'd2));
      tbl.push_back(mk(1, 0, 1, 1, 2'b11,  2'sd0, 0, 0, 2'd2));
`else
      tbl.push_back(mk(1, 1, 1, 1, 2'b10, -2'sd1, 0, 0, 2'd0));
      tbl.push_back(mk(1, 1, 1, 1, 2'b11,  2'sd0, 0, 0, 2'd0));
      tbl.push_back(mk(1, 1, 1, 1, 2'b00,  2'sd1, 0, 0, 2'd0));
      tbl.push_back(mk(1, 1, 1, 1, 2'b01,  2'sd0, 0, 0, 2'd0));
      tbl.push_back(mk(1, 1, 1, 1, 2'b10, -2'sd1, 0, 0, 2'd0));
      tbl.push_back(mk(1, 1, 1, 1, 2'b11,  2'sd0, 0, 1, 2'd0));
      tbl.push_back(mk(1, 1, 1, 1, 2'b00,  2'sd1, 0, 1, 2'd0));
      tbl.push_back(mk(1, 1, 1, 1, 2'b01,  2'sd0, 0, 1, 2'd0));
      tbl.push_back(mk(1, 1, 1, 1, 2'b10, -2'sd1, 0, 1, 2'd0));
      tbl.push_back(mk(1, 1, 1, 1, 2'b11,  2'sd0, 0, 1, 2'd0));
      tbl.push_back(mk(1, 0, 1, 1, 2'b11,  2'sd0, 0, 0, 2'd0));
      tbl.push_back(mk(0, 0, 1, 0, 2'b11,  2'sd0, 0, 0, 2'd0));
      tbl.push_back(mk(1, 1, 1, 1, 2'b00,  2'sd1, 0, 0, 2'd0));
`endif
      foreach (tbl[i]) step(1'b0, tbl[i], $sformatf("tbl[%0d]", i));

`ifdef MLT3_STUFF_EN
      // Six 1s then in_valid dropped: the stuff bit must still go out.
      step(0, mk(1, 1, 1, 1, 2'b00,  2'sd1, 0, 0, 2'd2), "idle_stuff.0");
      step(0, mk(1, 1, 1, 1, 2'b01,  2'sd0, 0, 0, 2'd2), "idle_stuff.1");
      step(0, mk(1, 1, 1, 1, 2'b10, -2'sd1, 0, 0, 2'd2), "idle_stuff.2");
      step(0, mk(1, 1, 1, 1, 2'b11,  2'sd0, 0, 0, 2'd2), "idle_stuff.3");
      step(0, mk(1, 1, 1, 1, 2'b00,  2'sd1, 0, 0, 2'd2), "idle_stuff.4");
      step(0, mk(1, 1, 1, 1, 2'b01,  2'sd0, 0, 1, 2'd2), "idle_stuff.5");
      step(0, mk(0, 0, 0, 1, 2'b01,  2'sd0, 1, 0, 2'd3), "idle_stuff.stuff");

      // Run of zeros to a fourth stuff: counter must hold at all-ones.
      for (int i = 0; i < 4; i++)
         step(0, mk(1, 0, 1, 1, 2'b01, 2'sd0, 0, 0, 2'd3), $sformatf("sat.zero%0d", i));
      step(0, mk(1, 0, 1, 1, 2'b01,  2'sd0, 0, 1, 2'd3), "sat.zero4");
      step(0, mk(1, 0, 0, 1, 2'b10, -2'sd1, 1, 0, 2'd3), "sat.stuff");

      // Build a full run, then reset in the stuff cycle: the pending stuff is dropped.
      step(0, mk(1, 1, 1, 1, 2'b11,  2'sd0, 0, 0, 2'd3), "rst_stuff.0");
      step(0, mk(1, 1, 1, 1, 2'b00,  2'sd1, 0, 0, 2'd3), "rst_stuff.1");
      step(0, mk(1, 1, 1, 1, 2'b01,  2'sd0, 0, 0, 2'd3), "rst_stuff.2");
      step(0, mk(1, 1, 1, 1, 2'b10, -2'sd1, 0, 0, 2'd3), "rst_stuff.3");
      step(0, mk(1, 1, 1, 1, 2'b11,  2'sd0, 0, 1, 2'd3), "rst_stuff.4");
      step(1, mk(1, 1, 0, 0, 2'b01,  2'sd0, 0, 0, 2'd0), "rst_stuff.rst");
      step(0, mk(1, 1, 1, 1, 2'b10, -2'sd1, 0, 0, 2'd0), "fresh.0");
      step(0, mk(1, 1, 1, 1, 2'b11,  2'sd0, 0, 0, 2'd0), "fresh.1");
      step(0, mk(1, 1, 1, 1, 2'b00,  2'sd1, 0, 0, 2'd0), "fresh.2");
      step(0, mk(1, 1, 1, 1, 2'b01,  2'sd0, 0, 0, 2'd0), "fresh.3");
      step(0, mk(1, 1, 1, 1, 2'b10, -2'sd1, 0, 0, 2'd0), "fresh.4");
      step(0, mk(1, 1, 1, 1, 2'b11,  2'sd0, 0, 1, 2'd0), "fresh.5");
      step(0, mk(1, 1, 0, 1, 2'b11,  2'sd0, 1, 0, 2'd1), "fresh.stuff");
`else
      // Reset mid-run clears the run detector; in_ready never drops.
      step(0, mk(1, 1, 1, 1, 2'b01,  2'sd0, 0, 0, 2'd0), "rst_run.0");
      step(0, mk(1, 1, 1, 1, 2'b10, -2'sd1, 0, 0, 2'd0), "rst_run.1");
      step(0, mk(1, 1, 1, 1, 2'b11,  2'sd0, 0, 0, 2'd0), "rst_run.2");
      step(0, mk(1, 1, 1, 1, 2'b00,  2'sd1, 0, 0, 2'd0), "rst_run.3");
      step(0, mk(1, 1, 1, 1, 2'b01,  2'sd0, 0, 1, 2'd0), "rst_run.4");
      step(1, mk(1, 1, 1, 0, 2'b01,  2'sd0, 0, 0, 2'd0), "rst_run.rst");
      step(0, mk(1, 1, 1, 1, 2'b10, -2'sd1, 0, 0, 2'd0), "fresh.0");
      step(0, mk(1, 1, 1, 1, 2'b11,  2'sd0, 0, 0, 2'd0), "fresh.1");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mlt3_stuff_encoder.md
# mlt3_stuff_encoder

Parametrised MLT-3 line encoder with run-length-limiting bit stuffing and a valid/ready input handshake. It accepts one payload bit per cycle and drives a registered three-level MLT-3 symbol. After `MAX_RUN` identical consecutive line bits, it inserts one complement bit and back-pressures the source for that cycle. It sits between the serial bit source and the MLT-3 decoder/line driver, replacing the fixed 6-bit run-detect encoder.

## Interface
Parameters:
- `MAX_RUN`, 6: maximum count of identical consecutive line bits before a stuff bit is forced; legal range 2..63.
- `CNT_W`, 16: width of the stuffed-bit counter.
- `RST_STATE`, 2'b01: MLT-3 state code loaded on reset; the default is `down`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_bit` in 1: payload bit.
- `in_valid` in 1: `in_bit` is valid.
- `in_ready` out 1: encoder accepts `in_bit` this cycle; combinational.
- `out_valid` out 1: a line bit was emitted; registered.
- `out_level` out 2, signed: MLT-3 level, one of +1, 0 or −1; registered.
- `out_code` out 2: MLT-3 state code (`top` 00, `down` 01, `bottom` 10, `up` 11); registered.
- `out_stuffed` out 1: the emitted bit is a stuff bit; registered.
- `run_hit` out 1: the current run length equals `MAX_RUN`; registered.
- `stuff_cnt` out `CNT_W`: number of stuff bits inserted since reset; saturates at all-ones.

## Operation
- **Line bit per cycle.** Exactly one of three events occurs each cycle:
  - **Stuff:** taken when `run_len == MAX_RUN`. The line bit is `~last_bit`.
  - **Accept:** taken when not stuffing and `in_valid && in_ready`. The line bit is `in_bit`.
  - **Idle:** taken otherwise. No line bit is emitted.
- **Handshake.**
  - `in_ready = ~(run_len == MAX_RUN)`.
  - A transfer occurs on `in_valid && in_ready`.
  - The source holds `in_bit` stable while `in_valid && !in_ready`.
- **Stuff independence.** A stuff bit is emitted in the cycle immediately after the run completes, whether or not `in_valid` is high.
- **Run tracking.** `run_len` is `clog2(MAX_RUN+1)` bits wide and counts line bits, so stuff bits are counted.
  - If the line bit equals `last_bit`, `run_len` increments.
  - Otherwise `run_len` becomes 1.
  - `last_bit` is updated with the line bit.
  - Idle cycles leave `run_len` and `last_bit` unchanged.
- **MLT-3 state machine.** A line bit of 1 advances the state in the order `top → down → bottom → up → top`. A line bit of 0, or an idle cycle, holds the state.
- **Level mapping.** `top` = +1, `bottom` = −1, `down` = 0, `up` = 0.
- **Stuff counter.** `stuff_cnt` increments on every stuff event and saturates at 2^`CNT_W`−1.
- **Reset values.**

  | Signal | Reset value |
  |---|---|
  | state | `RST_STATE` |
  | `out_code` | `RST_STATE` |
  | `out_level` | level of `RST_STATE` (0 for the default) |
  | `run_len` | 0 |
  | `last_bit` | 0 |
  | `out_valid` | 0 |
  | `out_stuffed` | 0 |
  | `run_hit` | 0 |
  | `stuff_cnt` | 0 |

  Because `run_len` resets to 0, the first line bit after reset starts a run of 1 regardless of its value.
- **Reset priority.** Reset mid-run or during a pending stuff discards the pending stuff. `in_ready` is 1 in the cycle after reset is released.

## Timing
- **Latency.** A bit accepted or stuffed in cycle n appears on `out_code`, `out_level`, `out_valid` and `out_stuffed` in cycle n+1.
- **Run limit.** After the `MAX_RUN`-th identical line bit (emitted in cycle n):
  - `run_hit` = 1 in cycle n+1.
  - `in_ready` = 0 in cycle n+1, and the stuff bit is emitted that cycle.
  - The stuff bit is visible in cycle n+2, with `out_stuffed` = 1 and `run_hit` = 0.
  - `in_ready` = 1 again in cycle n+2.
- **Throughput.** The maximum sustained payload rate is `MAX_RUN` bits per `MAX_RUN`+1 cycles for constant input. Alternating input never stalls.
- **Idle.** An idle cycle produces `out_valid` = 0 in the next cycle. `out_code`, `out_level` and `run_hit` hold their values.

## Configuration
- **`MLT3_STUFF_EN` defined:** stuffing behaves as described above.
- **`MLT3_STUFF_EN` undefined:**
  - `in_ready` is tied to 1.
  - Stuff events never occur.
  - `out_stuffed` and `stuff_cnt` are constant 0.
  - `run_len` still counts, saturating at `MAX_RUN`, and `run_hit` still flags runs as a status-only detector.

## Test plan
1. **Reset.** Assert `rst` for 2 cycles → `out_code`=01, `out_level`=0, `out_valid`=0, `in_ready`=1, `stuff_cnt`=0.
2. **Ones sequence.** `MAX_RUN`=6 with `MLT3_STUFF_EN`; stream 1,1,1,1 → `out_code` sequence 10, 11, 00, 01 and `out_level` sequence −1, 0, +1, 0.
3. **Run of ones.** Six 1s, with `in_valid` held high → in_ready=0 in the cycle after the sixth bit is accepted; a stuff 0 is emitted with `out_stuffed`=1 and the state held; `stuff_cnt`=1; the seventh payload bit is accepted on the next cycle.
4. **Run of zeros.** Six 0s from `down` → a stuff 1 advances the state to `bottom` with `out_level`=−1; the state stays at `down` through the zeros.
5. **Stuff while idle, and reset during a pending stuff.**
   - Drop `in_valid` right after the sixth identical bit → the stuff bit is still emitted.
   - Repeat with `rst` asserted in the stuff cycle → no stuff is emitted, and `run_len` starts afresh.
6. **Stuffing compiled out.** Build without `MLT3_STUFF_EN`; stream ten 1s → `in_ready` stays 1, there are no stuff bits, `run_hit`=1 from the cycle after the sixth bit, `stuff_cnt`=0.
